// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Performs the data-RAM access over a
// req/ack handshake or the UART MMIO access (0xBFD003F8 data, 0xBFD003FC
// status), and produces one write-back/forwarding result per accepted op.
// Optional ack watchdog: define MEM_ACK_TIMEOUT_EN.
module mem_access #(
  parameter int WORD = 32
`ifdef MEM_ACK_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [WORD-1:0] alu_out,
  input  logic [WORD-1:0] st_data,
  input  logic [1:0]      is_dmem,
  input  logic [1:0]      io_info,
  input  logic [4:0]      rd_in,
  input  logic            reg_we_in,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [WORD-1:0] dmem_addr,
  output logic [WORD-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [WORD-1:0] dmem_rdata,
  output logic            uart_tx_valid,
  output logic [7:0]      uart_tx_data,
  input  logic            uart_tx_ready,
  input  logic            uart_rx_valid,
  input  logic [7:0]      uart_rx_data,
  output logic            uart_rx_pop,
  output logic            wb_valid,
  output logic [WORD-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            mem_err
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_TX} state_t;
  state_t state, state_nx;

  // Op decode; {1,1} on is_dmem counts as a store.
  logic accept, st_flag, ld_flag, io_op, ram_op;
  logic io_ld, io_status, io_data, tx_start;
  logic [WORD-1:0] io_rdata;
  logic timeout;

  // The IO "state" flag is redundant with address bit 2.
  logic unused_io_state;
  assign unused_io_state = io_info[1];

  assign accept    = in_valid & (state == IDLE);
  assign st_flag   = is_dmem[1];
  assign ld_flag   = is_dmem[0] & ~is_dmem[1];
  assign io_op     = io_info[0];
  assign ram_op    = ~io_op & (|is_dmem);
  assign io_ld     = io_op & ld_flag;
  assign io_status = io_ld & alu_out[2];
  assign io_data   = io_ld & ~alu_out[2];
  assign tx_start  = io_op & st_flag & ~alu_out[2];

  assign io_rdata = io_status ? {{(WORD-2){1'b0}}, uart_rx_valid, uart_tx_ready} :
                    (io_data & uart_rx_valid) ? {{(WORD-8){1'b0}}, uart_rx_data} :
                    io_data ? '0 : alu_out;

  assign stall       = (state != IDLE);
  assign uart_rx_pop = accept & io_data & uart_rx_valid;

  // Op fields kept for the completion of multi-cycle ops.
  logic [WORD-1:0] op_addr;
  logic [4:0]      op_rd;
  logic            op_we, op_ld;

`ifdef MEM_ACK_TIMEOUT_EN
  logic [7:0] wd_cnt;
  assign timeout = (state == WAIT_ACK) & ~dmem_ack & (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog counts consecutive cycles spent waiting for ack.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_ACK) wd_cnt <= '0;
    else                          wd_cnt <= wd_cnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept && ram_op)        state_nx = WAIT_ACK;
                else if (accept && tx_start) state_nx = WAIT_TX;
      WAIT_ACK: if (dmem_ack || timeout)     state_nx = IDLE;
      WAIT_TX:  if (uart_tx_ready)           state_nx = IDLE;
      default:                               state_nx = IDLE;
    endcase
  end

  // Datapath: RAM/UART request registers and the single-pulse WB result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_we         <= 1'b0;
      op_addr       <= '0;
      op_rd         <= '0;
      op_we         <= 1'b0;
      op_ld         <= 1'b0;
`ifdef MEM_ACK_TIMEOUT_EN
      mem_err       <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_ACK_TIMEOUT_EN
      mem_err  <= 1'b0;
`endif
      if (accept) begin
        op_addr <= alu_out;
        op_rd   <= rd_in;
        op_we   <= reg_we_in & ~st_flag;
        op_ld   <= ld_flag;
      end
      case (state)
        IDLE: if (accept) begin
          if (ram_op) begin
            dmem_req   <= 1'b1;
            dmem_we    <= st_flag;
            dmem_addr  <= alu_out;
            dmem_wdata <= st_data;
          end else if (tx_start) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= st_data[7:0];
          end else begin
            // Pass-through, IO loads and ignored IO stores finish at once.
            wb_valid <= 1'b1;
            wb_data  <= io_rdata;
            wb_rd    <= rd_in;
            wb_we    <= reg_we_in & ~st_flag;
          end
        end
        WAIT_ACK: if (dmem_ack) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          wb_valid <= 1'b1;
          wb_data  <= op_ld ? dmem_rdata : op_addr;
          wb_rd    <= op_rd;
          wb_we    <= op_we;
        end else if (timeout) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          wb_valid <= 1'b1;
          wb_data  <= WORD'(32'hDEADBEEF);
          wb_rd    <= op_rd;
          wb_we    <= op_we;
`ifdef MEM_ACK_TIMEOUT_EN
          mem_err  <= 1'b1;
`endif
        end
        WAIT_TX: if (uart_tx_ready) begin
          uart_tx_valid <= 1'b0;
          wb_valid      <= 1'b1;
          wb_data       <= op_addr;
          wb_rd         <= op_rd;
          wb_we         <= op_we;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected WB results,
// a negedge monitor pops and compares on every wb_valid.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_out, st_data, dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic [1:0]  is_dmem, io_info;
  logic [4:0]  rd_in, wb_rd;
  logic        reg_we_in, stall, dmem_req, dmem_we, dmem_ack;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_pop;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        wb_valid, wb_we, mem_err;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_out(alu_out),
    .st_data(st_data), .is_dmem(is_dmem), .io_info(io_info), .rd_in(rd_in),
    .reg_we_in(reg_we_in), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
    .uart_tx_ready(uart_tx_ready), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_rx_pop(uart_rx_pop),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .mem_err(mem_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        chk;   // compare data only where the result is defined
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every WB pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) check("wb_data", wb_data, e.data);
        check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        check("wb_we", {31'b0, wb_we}, {31'b0, e.we});
      end
    end
`ifndef MEM_ACK_TIMEOUT_EN
    if (mem_err) check("mem_err_tied", {31'b0, mem_err}, 32'd0);
`endif
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] s, input logic [1:0] d,
                         input logic [1:0] io, input logic [4:0] r, input logic w);
    alu_out = a; st_data = s; is_dmem = d; io_info = io; rd_in = r; reg_we_in = w;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] s, input logic [1:0] d,
                       input logic [1:0] io, input logic [4:0] r, input logic w);
    present(a, s, d, io, r, w);
    check("accept_stall", {31'b0, stall}, 32'd0);
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    int sc, cnt, n;
    rst = 1'b1; in_valid = 1'b0; alu_out = '0; st_data = '0; is_dmem = '0;
    io_info = '0; rd_in = '0; reg_we_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;
    repeat (3) tick;
    rst = 1'b0;

    // Reset state
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_req", {31'b0, dmem_req}, 32'd0);
    check("rst_we", {31'b0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'd0);
    check("rst_rx_pop", {31'b0, uart_rx_pop}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_err", {31'b0, mem_err}, 32'd0);

    // Pass-through; stray ack/ready in IDLE must be ignored
    sb.push_back('{32'h1234, 5'd3, 1'b1, 1'b1});
    dmem_ack = 1'b1; uart_tx_ready = 1'b1;
    issue(32'h1234, 32'h0, 2'b00, 2'b00, 5'd3, 1'b1);
    check("pt_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("pt_stall", {31'b0, stall}, 32'd0);
    check("pt_req", {31'b0, dmem_req}, 32'd0);
    check("pt_tx_valid", {31'b0, uart_tx_valid}, 32'd0);
    dmem_ack = 1'b0; uart_tx_ready = 1'b0;
    tick;
    check("pt_single", {31'b0, wb_valid}, 32'd0);

    // RAM load 0x100, ack in cycle 3; in_valid while stalled is not accepted
    dmem_rdata = 32'hCAFEF00D;
    sb.push_back('{32'hCAFEF00D, 5'd5, 1'b1, 1'b1});
    issue(32'h100, 32'h0, 2'b01, 2'b00, 5'd5, 1'b1);
    sc = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) begin
        check("ld_req", {31'b0, dmem_req}, 32'd1);
        check("ld_we", {31'b0, dmem_we}, 32'd0);
      end
      check("ld_addr", dmem_addr, 32'h100);
      if (c < 3) present(32'h9999, 32'h0, 2'b00, 2'b00, 5'd1, 1'b1);
      else in_valid = 1'b0;
      dmem_ack = (c == 3);
      if (stall) sc++;
      tick;
    end
    dmem_ack = 1'b0;
    check("ld_stall_cycles", sc, 32'd3);
    check("ld_stall_done", {31'b0, stall}, 32'd0);
    check("ld_req_drop", {31'b0, dmem_req}, 32'd0);
    check("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
    tick;

    // RAM store, is_dmem=11 decodes as store; ack in the first wait cycle
    sb.push_back('{32'h200, 5'd7, 1'b0, 1'b1});
    issue(32'h200, 32'h11223344, 2'b11, 2'b00, 5'd7, 1'b1);
    check("st_req", {31'b0, dmem_req}, 32'd1);
    check("st_we", {31'b0, dmem_we}, 32'd1);
    check("st_wdata", dmem_wdata, 32'h11223344);
    check("st_stall", {31'b0, stall}, 32'd1);
    dmem_ack = 1'b1;
    tick;
    dmem_ack = 1'b0;
    check("st_stall_done", {31'b0, stall}, 32'd0);
    check("st_req_drop", {31'b0, dmem_req}, 32'd0);
    check("st_wb_valid", {31'b0, wb_valid}, 32'd1);

    // UART TX store, ready low 4 cycles then high
    sb.push_back('{32'h0, 5'd0, 1'b0, 1'b0});
    issue(32'hBFD003F8, 32'h0000FFA5, 2'b10, 2'b01, 5'd0, 1'b1);
    cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      uart_tx_ready = (c == 5);
      if (uart_tx_valid && uart_tx_data == 8'hA5) cnt++;
      tick;
    end
    uart_tx_ready = 1'b0;
    check("tx_hold_cycles", cnt, 32'd5);
    check("tx_valid_drop", {31'b0, uart_tx_valid}, 32'd0);
    check("tx_wb_valid", {31'b0, wb_valid}, 32'd1);
    tick;

    // UART status load, then data load with pop, then data load with empty RX
    uart_rx_valid = 1'b1; uart_rx_data = 8'h41;
    sb.push_back('{32'h2, 5'd9, 1'b1, 1'b1});
    present(32'hBFD003FC, 32'h0, 2'b01, 2'b01, 5'd9, 1'b1);
    #1 check("status_no_pop", {31'b0, uart_rx_pop}, 32'd0);
    tick;
    sb.push_back('{32'h41, 5'd10, 1'b1, 1'b1});
    present(32'hBFD003F8, 32'h0, 2'b01, 2'b01, 5'd10, 1'b1);
    #1 check("rx_pop", {31'b0, uart_rx_pop}, 32'd1);
    tick;
    in_valid = 1'b0;
    #1 check("rx_pop_single", {31'b0, uart_rx_pop}, 32'd0);
    uart_rx_valid = 1'b0;
    sb.push_back('{32'h0, 5'd11, 1'b1, 1'b1});
    present(32'hBFD003F8, 32'h0, 2'b01, 2'b01, 5'd11, 1'b1);
    #1 check("rx_empty_no_pop", {31'b0, uart_rx_pop}, 32'd0);
    tick;
    in_valid = 1'b0;

    // IO store to status address is ignored
    sb.push_back('{32'hBFD003FC, 5'd12, 1'b0, 1'b1});
    issue(32'hBFD003FC, 32'h77, 2'b10, 2'b01, 5'd12, 1'b0);
    check("iost_tx_valid", {31'b0, uart_tx_valid}, 32'd0);
    check("iost_stall", {31'b0, stall}, 32'd0);
    check("iost_wb_valid", {31'b0, wb_valid}, 32'd1);
    tick;

    // Reset while waiting for ack: no WB result
    issue(32'h300, 32'h0, 2'b01, 2'b00, 5'd13, 1'b1);
    check("rm_req", {31'b0, dmem_req}, 32'd1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rm_req_drop", {31'b0, dmem_req}, 32'd0);
    check("rm_stall", {31'b0, stall}, 32'd0);
    check("rm_wb_valid", {31'b0, wb_valid}, 32'd0);
    repeat (3) tick;

`ifdef MEM_ACK_TIMEOUT_EN
    // Watchdog: load with no ack
    sb.push_back('{32'hDEADBEEF, 5'd14, 1'b1, 1'b1});
    issue(32'h400, 32'h0, 2'b01, 2'b00, 5'd14, 1'b1);
    n = 1;
    while (!wb_valid && n < 400) begin
      tick;
      n++;
    end
    check("wd_latency", n, 32'd256);
    check("wd_mem_err", {31'b0, mem_err}, 32'd1);
    check("wd_req_drop", {31'b0, dmem_req}, 32'd0);
    tick;
    check("wd_mem_err_pulse", {31'b0, mem_err}, 32'd0);
`else
    n = 0;
`endif

    repeat (2) tick;
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Pipeline MEM stage sitting directly downstream of the execute stage. It consumes the registered execute results: ALU result as address, forwarded store data, load/store flags and IO flags. It then performs the data-RAM access over a req/ack handshake, or the UART MMIO access at 0xBFD003F8/0xBFD003FC. It produces the write-back result, which is also the MEM-stage forwarding value, and stalls upstream while a transaction is outstanding.

## Interface
- `WORD`, 32, datapath width
- `TIMEOUT_CYCLES`, 255, ack watchdog limit (only with `MEM_ACK_TIMEOUT_EN`)
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: op presented from the EX/MEM register
- `alu_out` in WORD: address, or pass-through result
- `st_data` in WORD: store data
- `is_dmem` in 2: {is_store, is_load}
- `io_info` in 2: {is_io_state, is_io}; only bit 0 is used, address bit 2 selects data/state
- `rd_in` in 5: destination register
- `reg_we_in` in 1: register write enable
- `stall` out 1: upstream must hold its op
- `dmem_req` out 1: RAM request
- `dmem_we` out 1: RAM write
- `dmem_addr` out WORD: RAM address
- `dmem_wdata` out WORD: RAM write data
- `dmem_ack` in 1: RAM done
- `dmem_rdata` in WORD: RAM read data
- `uart_tx_valid` out 1: TX byte valid
- `uart_tx_data` out 8: TX byte
- `uart_tx_ready` in 1: TX can accept a byte
- `uart_rx_valid` in 1: RX byte available
- `uart_rx_data` in 8: RX byte
- `uart_rx_pop` out 1: consume RX byte (1-cycle pulse)
- `wb_valid` out 1: result valid to WB
- `wb_data` out WORD: result to WB, and forwarding value
- `wb_rd` out 5: destination register to WB
- `wb_we` out 1: register write enable to WB
- `mem_err` out 1: watchdog fired (1-cycle pulse)

## Operation
- Accept: `in_valid & !stall`. Op is latched internally: addr, data, rd, we, kind.
- Kind decode, in order:
  - `is_dmem==2'b11` is treated as a store.
  - IO if `io_info[0]`, else RAM if any `is_dmem` bit is set, else pass-through.
- FSM has three states: IDLE, WAIT_ACK, WAIT_TX.
- `stall` = state != IDLE.
- Pass-through, IDLE:
  - next cycle `wb_valid=1`, `wb_data=alu_out`.
  - Stays IDLE.
- RAM op, IDLE → WAIT_ACK:
  - `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` are registered and held constant until the cycle `dmem_ack=1`.
  - On ack: return to IDLE and drop `dmem_req`.
  - Next cycle `wb_valid=1`, `wb_data` = `dmem_rdata` for a load, `alu_out` for a store.
  - `wb_we=0` for a store.
- IO load 0xBFD003FC, IDLE stays: `wb_data={30'b0, uart_rx_valid, uart_tx_ready}`, sampled in the accept cycle.
- IO load 0xBFD003F8, IDLE stays:
  - If `uart_rx_valid`: `wb_data={24'b0, uart_rx_data}` and `uart_rx_pop` pulses in the accept cycle.
  - Otherwise `wb_data=0` with no pop.
- IO store 0xBFD003F8, IDLE → WAIT_TX:
  - `uart_tx_valid=1` and `uart_tx_data=st_data[7:0]` are held until `uart_tx_ready`.
  - Then return to IDLE; `wb_valid` next cycle.
- IO store 0xBFD003FC: ignored, completes like a pass-through.
- Every accepted op yields exactly one `wb_valid` pulse. `wb_rd` and `wb_we` travel with it.

## Timing
- Reset values:
  - state IDLE
  - `stall`, `dmem_req`, `dmem_we`, `uart_tx_valid`, `uart_rx_pop`, `wb_valid`, `wb_we`, `mem_err` = 0
  - all data/address outputs = 0
- Pass-through and IO loads: latency 1, no stall.
- RAM: accept at cycle 0, `dmem_req` high from cycle 1, ack at cycle N≥1, `wb_valid` at N+1, `stall` high cycles 1..N.
- `dmem_ack` or `uart_tx_ready` outside the wait state is ignored.
- Reset mid-transaction: the request is abandoned the same edge and no `wb_valid` is produced. The RAM must tolerate a dropped request.
- `in_valid` while `stall=1` is not accepted; upstream re-presents the op.

## Configuration
- `MEM_ACK_TIMEOUT_EN` defined:
  - An 8-bit counter runs in WAIT_ACK.
  - After `TIMEOUT_CYCLES` cycles without ack: `dmem_req` drops, `mem_err` pulses, the state returns to IDLE, and `wb_valid` is issued next cycle with `wb_data=32'hDEADBEEF`.
- Undefined: no counter; WAIT_ACK waits indefinitely and `mem_err` is tied to 0.

## Test plan
- Pass-through:
  - Stimulus: `alu_out=0x1234`, `is_dmem=0`.
  - Response: `wb_valid` next cycle, `wb_data=0x1234`, `stall` never high.
- Load 0x100:
  - Stimulus: ack after 3 cycles, `dmem_rdata=0xCAFEF00D`.
  - Response: `stall` high 3 cycles, `wb_data=0xCAFEF00D` one cycle after ack.
- Store:
  - Stimulus: `st_data=0xA5` to 0xBFD003F8, `uart_tx_ready` low for 4 cycles.
  - Response: `uart_tx_valid` held 5 cycles with `tx_data=0xA5`, then one `wb_valid` with `wb_we=0`.
- Load 0xBFD003FC:
  - Stimulus: `rx_valid=1`, `tx_ready=0`.
  - Response: `wb_data=0x2`.
  - Follow-on: then load 0xBFD003F8 with `rx_data=0x41` gives `wb_data=0x41` and one `uart_rx_pop` pulse.
- Reset mid-transaction:
  - Stimulus: assert `rst` while in WAIT_ACK.
  - Response: next cycle `dmem_req=0`, `stall=0`, no `wb_valid`.
- Watchdog (`MEM_ACK_TIMEOUT_EN`):
  - Stimulus: load with no ack.
  - Response: after 255 cycles `mem_err` pulses, `wb_data=0xDEADBEEF`.
